// File: rtl/lc2k_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc2k_pkg : shared LC2K opcode constants, field positions, fetch FSM  |
// | Rev 1.0  : initial release                                           |
// +----------------------------------------------------------------------+
package lc2k_pkg;

    localparam logic [2:0] c_OP_ADD  = 3'd0;
    localparam logic [2:0] c_OP_NOR  = 3'd1;
    localparam logic [2:0] c_OP_LW   = 3'd2;
    localparam logic [2:0] c_OP_SW   = 3'd3;
    localparam logic [2:0] c_OP_BEQ  = 3'd4;
    localparam logic [2:0] c_OP_JALR = 3'd5;
    localparam logic [2:0] c_OP_HALT = 3'd6;
    localparam logic [2:0] c_OP_NOOP = 3'd7;

    localparam int c_OPCODE_MSB = 24;
    localparam int c_OPCODE_LSB = 22;
    localparam int c_REGA_MSB   = 21;
    localparam int c_REGA_LSB   = 19;
    localparam int c_REGB_MSB   = 18;
    localparam int c_REGB_LSB   = 16;
    localparam int c_OFFSET_MSB = 15;
    localparam int c_OFFSET_LSB = 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        FAULT  = 2'd3
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/lc2k_fetch_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc2k_fetch_if : fetch sequencer <-> CPU datapath / instruction memory |
// | Optional: LC2K_FETCH_INSTR_COUNT_EN adds instr_count                 |
// | Rev 1.0       : initial release                                      |
// +----------------------------------------------------------------------+
interface lc2k_fetch_if;
    logic        start;
    logic [31:0] instr;
    logic [31:0] regA_val;
    logic        alu_eq;
    logic [31:0] pcCurrent;
    logic [31:0] pcPlusOne;
    logic        running;
    logic        halted;
    logic        fault;
`ifdef LC2K_FETCH_INSTR_COUNT_EN
    logic [31:0] instr_count;
`endif

    modport master (
        input  start, instr, regA_val, alu_eq,
        output pcCurrent, pcPlusOne, running, halted, fault
`ifdef LC2K_FETCH_INSTR_COUNT_EN
        , output instr_count
`endif
    );

    modport slave (
        output start, instr, regA_val, alu_eq,
        input  pcCurrent, pcPlusOne, running, halted, fault
`ifdef LC2K_FETCH_INSTR_COUNT_EN
        , input instr_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/lc2k_next_pc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc2k_next_pc : combinational next-PC select and fetch range check    |
// | Rev 1.0      : initial release                                       |
// +----------------------------------------------------------------------+
module lc2k_next_pc
    import lc2k_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 10
) (
    input  wire logic [31:0] pc,
    input  wire logic [31:0] instr,
    input  wire logic [31:0] regA_val,
    input  wire logic        alu_eq,
    output logic      [31:0] next_pc,
    output logic             is_halt,
    output logic             out_of_range
);

    logic [2:0]  w_opcode;
    logic [2:0]  w_rega;
    logic [2:0]  w_regb;
    logic [31:0] w_sext_off;
    logic [31:0] w_pc_inc;
    logic        w_unused;

    assign w_opcode   = instr[c_OPCODE_MSB:c_OPCODE_LSB];
    assign w_rega     = instr[c_REGA_MSB:c_REGA_LSB];
    assign w_regb     = instr[c_REGB_MSB:c_REGB_LSB];
    assign w_sext_off = {{16{instr[c_OFFSET_MSB]}}, instr[c_OFFSET_MSB:c_OFFSET_LSB]};
    assign w_pc_inc   = pc + 32'd1;
    assign w_unused   = ^instr[31:25];

    always_comb begin
        next_pc = w_pc_inc;
        is_halt = 1'b0;
        case (w_opcode)
            c_OP_BEQ:  if (alu_eq) next_pc = w_pc_inc + w_sext_off;
            // Same-register jalr writes the link before the jump reads it.
            c_OP_JALR: if (w_rega != w_regb) next_pc = regA_val;
            c_OP_HALT: is_halt = 1'b1;
            default:   next_pc = w_pc_inc;
        endcase
    end

    assign out_of_range = (next_pc >= 32'(MEM_DEPTH));

endmodule
`default_nettype wire

// File: rtl/lc2k_fetch.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lc2k_fetch : LC2K PC register and IDLE/RUN/HALTED/FAULT sequencer    |
// | Optional: LC2K_FETCH_INSTR_COUNT_EN adds executed-instruction count  |
// | Rev 1.0    : initial release                                         |
// +----------------------------------------------------------------------+
module lc2k_fetch
    import lc2k_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 10,
    parameter logic [31:0] RESET_PC  = 32'd0
) (
    input  wire logic    clk,
    input  wire logic    reset,
    lc2k_fetch_if.master bus
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;
    logic [31:0]  r_pc;
    logic [31:0]  w_next_pc;
    logic         w_is_halt;
    logic         w_out_of_range;
    logic         w_pc_load;

    lc2k_next_pc #(
        .MEM_DEPTH (MEM_DEPTH)
    ) u_next_pc (
        .pc           (r_pc),
        .instr        (bus.instr),
        .regA_val     (bus.regA_val),
        .alu_eq       (bus.alu_eq),
        .next_pc      (w_next_pc),
        .is_halt      (w_is_halt),
        .out_of_range (w_out_of_range)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (bus.start) w_state_nxt = RUN;
            RUN: begin
                if (w_is_halt)           w_state_nxt = HALTED;
                else if (w_out_of_range) w_state_nxt = FAULT;
            end
            default: w_state_nxt = r_state;
        endcase
    end

    always_comb begin
        bus.running = (r_state == RUN);
        bus.halted  = (r_state == HALTED);
        bus.fault   = (r_state == FAULT);
        w_pc_load   = (r_state == RUN) && !w_is_halt && !w_out_of_range;
    end

    always_ff @(posedge clk) begin
        if (reset)          r_pc <= RESET_PC;
        else if (w_pc_load) r_pc <= w_next_pc;
    end

    assign bus.pcCurrent = r_pc;
    assign bus.pcPlusOne = r_pc + 32'd1;

`ifdef LC2K_FETCH_INSTR_COUNT_EN
    logic [31:0] r_instr_count;

    // Halt and faulting instructions still count: they occupied a RUN cycle.
    always_ff @(posedge clk) begin
        if (reset)               r_instr_count <= 32'd0;
        else if (r_state == RUN) r_instr_count <= r_instr_count + 32'd1;
    end

    assign bus.instr_count = r_instr_count;
`endif

endmodule
`default_nettype wire

// File: doc/lc2k_fetch.md
# lc2k_fetch

Program-counter and fetch sequencer for the LC2K single-cycle CPU. It sits directly upstream of the instruction memory: it drives `pcCurrent` into the memory and consumes the returned `instr` word. It then selects the next PC (sequential, `beq` target, `jalr` target) and tracks run, halt and fault status. One instruction is fetched per cycle while running.

## Interface
- `MEM_DEPTH`, default 10: number of instruction words; any PC ≥ `MEM_DEPTH` is a fetch fault.
- `RESET_PC`, default 0: PC value loaded on reset.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle pulse; moves IDLE to RUN.
- `instr`  in  32  instruction word from instruction memory at `pcCurrent`; combinational.
- `regA_val`  in  32  register-file read of the `regA` field; used as the `jalr` target.
- `alu_eq`  in  1  ALU equality flag (`regA == regB`) for the current instruction.
- `pcCurrent`  out  32  registered PC; feeds the instruction memory address.
- `pcPlusOne`  out  32  `pcCurrent + 1`, combinational; this is the `jalr` link value.
- `running`  out  1  high in RUN.
- `halted`  out  1  high in HALTED.
- `fault`  out  1  high in FAULT.
- `instr_count`  out  32  executed-instruction count; present only with `LC2K_FETCH_INSTR_COUNT_EN`.

## Operation
- Instruction field decode:
  - opcode = `instr[24:22]`: add=0, nor=1, lw=2, sw=3, beq=4, jalr=5, halt=6, noop=7.
  - `regA` = `[21:19]`, `regB` = `[18:16]`, offset = `[15:0]`, two's complement.
- States:
  - IDLE: after reset.
  - RUN.
  - HALTED.
  - FAULT.
- IDLE: `start`=1 moves to RUN; PC is unchanged.
- RUN: each cycle computes `next_pc`:
  - beq with `alu_eq`=1: `pc + 1 + sext(offset)`, mod 2^32.
  - beq with `alu_eq`=0: `pc + 1`.
  - jalr: `regA_val`. Exception: when `regA` field == `regB` field, `next_pc` = `pc + 1`, matching LC2K write-before-jump semantics.
  - halt: no `next_pc`; moves to HALTED and PC holds at the halt address.
  - all other opcodes: `pc + 1`.
- Fault check in RUN: if `next_pc` ≥ `MEM_DEPTH` (unsigned compare), move to FAULT and do not load PC; `pcCurrent` keeps the offending instruction's address.
- HALTED and FAULT are terminal: PC frozen, `start` ignored; only `reset` exits.
- `start` in RUN is ignored.

## Timing
- Reset values:
  - `pcCurrent` = `RESET_PC`.
  - state IDLE: `running`=0, `halted`=0, `fault`=0.
  - `instr_count` = 0.
- Reset takes priority over every other input, including mid-RUN. The state on the next edge is IDLE.
- Fetch latency: `instr` is valid the same cycle as `pcCurrent`. The new PC appears one edge later, giving 1 CPI.
- `start` sampled in IDLE: `running` goes high on the next edge. The instruction at `RESET_PC` executes in that first RUN cycle.
- Halt or fault decision is made in the cycle holding the instruction. The status flag rises on the following edge.
- `pcPlusOne` wraps: 0xFFFFFFFF + 1 = 0.

## Configuration
- `LC2K_FETCH_INSTR_COUNT_EN` defined:
  - `instr_count` port and register exist.
  - Increments by 1 on every RUN edge, including the halt instruction and the faulting instruction.
  - Wraps mod 2^32; frozen in HALTED and FAULT.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Structure
- Shared package `lc2k_pkg`:
  - opcode constants.
  - field bit positions.
  - `fetch_state_t` enum (IDLE/RUN/HALTED/FAULT).
- Sub-module `lc2k_next_pc`: purely combinational next-PC and fault-compare logic. Inputs are `pc`, `instr`, `regA_val` and `alu_eq`; outputs are `next_pc`, `is_halt` and `out_of_range`.
- The top level holds the PC register, state register and counter.

## Test plan
- Reset held 2 cycles → `pcCurrent`=0, `running`=`halted`=`fault`=0, `instr_count`=0; PC stays 0 in IDLE without `start`.
- `start` pulse, `instr`=0x01C00000 (noop) every cycle → `pcCurrent` = 0,1,2,3 on consecutive edges; `instr_count`=3 after the third RUN edge.
- beq at pc=2:
  - `instr`=0x01000003, `alu_eq`=1 → pc=6.
  - Same `instr`, `alu_eq`=0 → pc=3.
  - At pc=5, `instr`=0x0100FFFD, `alu_eq`=1 → pc=3.
- jalr:
  - At pc=1, `instr`=0x01530000 (jalr 2 3), `regA_val`=5 → `pcPlusOne`=2 that cycle, then pc=5.
  - `instr`=0x01490000 (jalr 1 1), `regA_val`=9 → pc=2.
- Halt at pc=6, `instr`=0x01800000 → `halted`=1 next edge, pc stays 6, count frozen; a later `start` has no effect.
- Fault and reset recovery:
  - `MEM_DEPTH`=10, pc=8, `instr`=0x01000005, `alu_eq`=1 → target 14 → `fault`=1, pc stays 8.
  - Then `reset` → IDLE, pc=0, all flags cleared.
